// File: rtl/hc86_xor_stream.sv
// Purpose: WIDTH-lane XOR/XNOR/accumulate/change-detect stream stage with a DEPTH-entry output FIFO.
// Latency: 1 cycle from accepted operand pair to Y when the FIFO is empty.
// Backpressure: IN_READY = not full OR OUT_READY, so a full FIFO still accepts when popping.
// Optional feature: define HC86_PARITY_EN to add Y_PAR (XOR-reduction of each result, stored in the FIFO).
module hc86_xor_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [WIDTH-1:0]             i_a,
    input  logic [WIDTH-1:0]             i_b,
    input  logic [1:0]                   i_mode,
    input  logic                         i_clr_acc,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [WIDTH-1:0]             o_y,
`ifdef HC86_PARITY_EN
    output logic                         o_y_par,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
`ifdef HC86_PARITY_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif

    localparam logic [1:0] MODE_XOR  = 2'b00;
    localparam logic [1:0] MODE_XNOR = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_DIFF = 2'b11;

    logic [FW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_prev_a;

    logic [WIDTH-1:0] w_ab;
    logic [WIDTH-1:0] w_res;
    logic [FW-1:0]    w_entry;
    logic [FW-1:0]    w_head;
    logic             w_push;
    logic             w_pop;

    assign w_ab        = i_a ^ i_b;
    assign o_out_valid = (r_count != '0);
    assign o_in_ready  = (r_count < CW'(DEPTH)) || i_out_ready;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;
    assign o_count     = r_count;
    assign w_head      = r_mem[r_rptr];
    assign o_y         = o_out_valid ? w_head[WIDTH-1:0] : '0;
`ifdef HC86_PARITY_EN
    assign w_entry     = {^w_res, w_res};
    assign o_y_par     = o_out_valid & w_head[WIDTH];
`else
    assign w_entry     = w_res;
`endif

    // Result of the current operand pair; a same-cycle clear zeroes the stateful term first.
    always_comb begin
        w_res = w_ab;
        case (i_mode)
            MODE_XOR:  w_res = w_ab;
            MODE_XNOR: w_res = ~w_ab;
            MODE_ACC:  w_res = i_clr_acc ? w_ab : (r_acc ^ w_ab);
            MODE_DIFF: w_res = i_clr_acc ? w_ab : (w_ab ^ r_prev_a);
            default:   w_res = w_ab;
        endcase
    end

    // Stateful operands: accepted pair always refreshes prev_a; clear applies even without a transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_prev_a <= '0;
        end else begin
            if (w_push && (i_mode == MODE_ACC)) begin
                r_acc <= w_res;
            end else if (i_clr_acc) begin
                r_acc <= '0;
            end
            if (w_push) begin
                r_prev_a <= w_ab;
            end else if (i_clr_acc) begin
                r_prev_a <= '0;
            end
        end
    end

    // Circular output buffer; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hc86_xor_stream.sv
// Bench for hc86_xor_stream (WIDTH=4, DEPTH=2): queue-based model compared every cycle,
// plus directed vectors with hand-computed literal results.
// Build with HC86_PARITY_EN defined to also exercise Y_PAR.
module tb_hc86_xor_stream;

    localparam int W = 4;
    localparam int D = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [3:0] a         = '0;
    logic [3:0] b         = '0;
    logic [1:0] mode      = '0;
    logic       clr       = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] y;
    logic [1:0] count;
`ifdef HC86_PARITY_EN
    logic       y_par;
`endif

    int checks = 0;
    int errors = 0;

    hc86_xor_stream #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_mode      (mode),
        .i_clr_acc   (clr),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_y         (y),
`ifdef HC86_PARITY_EN
        .o_y_par     (y_par),
`endif
        .o_count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending results plus accumulator and previous A^B.
    logic [3:0] q[$];
    logic [3:0] m_acc  = '0;
    logic [3:0] m_prev = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_acc  = '0;
                m_prev = '0;
            end else begin
                logic       push, pop;
                logic [3:0] ab, r;
                push = in_valid && ((q.size() < D) || out_ready);
                pop  = (q.size() != 0) && out_ready;
                ab   = a ^ b;
                if (pop) void'(q.pop_front());
                if (push) begin
                    case (mode)
                        2'd0: r = ab;
                        2'd1: r = ~ab;
                        2'd2: r = clr ? ab : (m_acc ^ ab);
                        default: r = clr ? ab : (ab ^ m_prev);
                    endcase
                    q.push_back(r);
                    if (mode == 2'd2) m_acc = r;
                    else if (clr) m_acc = '0;
                    m_prev = ab;
                end else if (clr) begin
                    m_acc  = '0;
                    m_prev = '0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out_valid", out_valid, q.size() != 0);
            chk("m_y", y, (q.size() != 0) ? q[0] : 4'd0);
            chk("m_count", count, q.size());
            chk("m_in_ready", in_ready, (q.size() < D) || out_ready);
`ifdef HC86_PARITY_EN
            chk("m_y_par", y_par, (q.size() != 0) ? ^q[0] : 1'b0);
`endif
        end
    end

    // One transfer into an empty FIFO; checks the literal result one cycle later.
    task automatic xfer(input logic [1:0] md, input logic [3:0] aa, input logic [3:0] bb,
                        input logic cl, input logic [3:0] exp, input string nm);
        @(posedge clk); #2;
        in_valid = 1'b1; mode = md; a = aa; b = bb; clr = cl; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; clr = 1'b0;
        @(negedge clk);
        chk(nm, y, exp);
        chk({nm, "_vld"}, out_valid, 1);
    endtask

    task automatic idle_clr();
        @(posedge clk); #2; clr = 1'b1;
        @(posedge clk); #2; clr = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_count", count, 0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // XOR, latency and pop
        xfer(2'b00, 4'b1100, 4'b1010, 1'b0, 4'b0110, "xor");
        chk("xor_count1", count, 1);
        @(negedge clk);
        chk("xor_count0", count, 0);

        xfer(2'b01, 4'hF, 4'h0, 1'b0, 4'h0, "xnor");

        // Accumulate, then again with clear on the third pair
        xfer(2'b10, 4'd1, 4'd0, 1'b0, 4'd1, "acc1");
        xfer(2'b10, 4'd2, 4'd0, 1'b0, 4'd3, "acc2");
        xfer(2'b10, 4'd4, 4'd1, 1'b0, 4'd6, "acc3");
        idle_clr();
        xfer(2'b10, 4'd1, 4'd0, 1'b0, 4'd1, "acc_c1");
        xfer(2'b10, 4'd2, 4'd0, 1'b0, 4'd3, "acc_c2");
        xfer(2'b10, 4'd4, 4'd1, 1'b1, 4'd5, "acc_c3");
        xfer(2'b10, 4'd0, 4'd0, 1'b0, 4'd5, "acc_hold");

        // Change detect (prev A^B is 0 here)
        xfer(2'b11, 4'd3, 4'd0, 1'b0, 4'd3, "diff1");
        xfer(2'b11, 4'd1, 4'd2, 1'b0, 4'd0, "diff2");
        xfer(2'b11, 4'd5, 4'd0, 1'b0, 4'd6, "diff3");
        xfer(2'b11, 4'd6, 4'd0, 1'b1, 4'd6, "diff_clr");

        // Fill with consumer stalled, then simultaneous pop and push
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00; a = 4'd1; b = 4'd0;
        @(posedge clk); #2; a = 4'd2;
        @(posedge clk); #2; a = 4'd3;
        @(negedge clk);
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", y, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("full_held", count, 2);
        @(posedge clk); #2; out_ready = 1'b1;
        @(posedge clk); #2; in_valid = 1'b0;
        @(negedge clk);
        chk("pp_count", count, 2);
        chk("pp_head", y, 2);
        @(negedge clk);
        chk("pp_next", y, 3);
        @(negedge clk);
        chk("pp_empty", out_valid, 0);

        // Asynchronous reset with two results buffered
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; a = 4'h9; b = 4'h0;
        repeat (2) @(posedge clk);
        #2 in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_y", y, 0);
        chk("arst_count", count, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

`ifdef HC86_PARITY_EN
        xfer(2'b00, 4'b0111, 4'b0000, 1'b0, 4'b0111, "par_y");
        chk("par_bit", y_par, 1);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc86_xor_stream.md
Name: hc86_xor_stream

Overview:
- Parametrised, clocked successor to the quad 2-input XOR gate block.
- Handles WIDTH XOR lanes with a valid/ready handshake on input and output.
- Four operating modes, two of which carry state between transfers: accumulating XOR and bitwise change detect.
- Results are buffered in a DEPTH-entry output FIFO, so the block sits between a stream producer and a consumer that may stall.

Parameters:
- WIDTH, 4, number of XOR lanes (bits of A, B, Y); legal range 1..64.
- DEPTH, 2, output FIFO entries; power of two, 2..16.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous reset, active low.
- IN_VALID  in  1  producer has an operand pair on A/B/MODE.
- IN_READY  out  1  block accepts a transfer this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- MODE  in  2  operation, sampled with the transfer: 00 XOR, 01 XNOR, 10 ACC, 11 DIFF.
- CLR_ACC  in  1  synchronous clear of the accumulator and the previous-A register.
- OUT_VALID  out  1  FIFO head holds a result.
- OUT_READY  in  1  consumer takes the head this cycle.
- Y  out  WIDTH  result at the FIFO head.
- COUNT  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO emptied; pointers, COUNT, acc and prev_a all cleared to 0.
  - OUT_VALID=0, Y=0, IN_READY=1 once reset is released.
- Transfers:
  - Input transfer: IN_VALID && IN_READY at a rising edge.
  - Output transfer: OUT_VALID && OUT_READY at a rising edge.
- IN_READY = (COUNT<DEPTH) || OUT_READY.
  - A full FIFO accepts a push in the same cycle as a pop.
  - IN_READY is combinational from OUT_READY; there is no other combinational input-to-output path.
- Latency: an operand pair accepted at edge k appears on Y with OUT_VALID=1 after edge k (1 cycle) when the FIFO was empty.
- Result computed at the accepting edge:
  - 00: r = A^B.
  - 01: r = ~(A^B).
  - 10: r = acc^A^B, and acc <= r.
  - 11: r = (A^B)^prev_a.
- prev_a <= A^B on every accepted transfer, in every mode.
- acc changes only in mode 10 or on CLR_ACC.
- CLR_ACC handling:
  - Effective every edge, whether or not a transfer occurs; sets acc=0 and prev_a=0.
  - If asserted in the same cycle as an accepted ACC transfer: r = A^B and acc <= A^B.
  - If asserted in the same cycle as an accepted DIFF transfer: r = A^B, then prev_a <= A^B.
- FIFO:
  - Circular buffer; write and read pointers wrap modulo DEPTH.
  - COUNT: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Pop when empty is impossible because OUT_VALID=0.
  - Y is forced to 0 whenever OUT_VALID=0.
  - Head data stays stable while OUT_VALID=1 and OUT_READY=0.
- MODE and CLR_ACC are ignored for results when no transfer occurs; CLR_ACC still clears state.
- Mid-operation reset discards all buffered results. No output transfer completes in the reset cycle.
- Arithmetic is purely bitwise; no carries between lanes.

Optional Feature:
- Macro HC86_PARITY_EN.
- When defined:
  - Extra output port Y_PAR (1 bit) = XOR-reduction of the stored result r.
  - Y_PAR is stored in the FIFO alongside r, so the FIFO width is WIDTH+1.
  - Y_PAR is 0 at reset and whenever OUT_VALID=0.
- When undefined: port Y_PAR is absent, FIFO width is WIDTH, and all other behaviour is identical.

Test Plan:
- Reset, then MODE=00, A=4'b1100, B=4'b1010, OUT_READY=1 -> next cycle Y=4'b0110, OUT_VALID=1, COUNT=1, then 0 after the pop.
- MODE=01, A=4'hF, B=4'h0 -> Y=4'h0.
- MODE=10 with pairs (1,0), (2,0), (4,1) -> Y=1, 3, 6.
- Same sequence with CLR_ACC asserted on the third pair -> third Y=5, acc=5.
- MODE=11, A^B sequence 3, 3, 5 -> Y=3, 0, 6.
- DEPTH=2, OUT_READY=0, push 3 items -> COUNT=2, IN_READY=0, third item held. Raise OUT_READY -> the pop and push complete in one cycle, COUNT stays 2, and results come out in order.
- Assert RST_N low with COUNT=2 -> OUT_VALID=0, Y=0, COUNT=0 immediately, without waiting for a clock edge. With HC86_PARITY_EN defined, Y=4'b0111 is accompanied by Y_PAR=1.
